csr_unit: RTL and testbench

Parametrised machine-mode CSR file; successor to the four-register trap CSR block in the pipe core.
- Reads CSRs combinationally at EX and applies CSRRW/CSRRS/CSRRC read-modify-write at WB.
- Performs trap entry and MRET state updates, samples interrupt lines and provides the trap target PC.
- Adds mstatus, mie, mip, mscratch, vectored mtvec, illegal-access detection and optional 64-bit cycle/instret counters.

---
 rtl/csr_pkg.sv | 39 +++
 rtl/csr_unit_if.sv | 26 ++
 rtl/csr_counter64.sv | 32 +++
 rtl/csr_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_csr_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit.
// Counter addresses are only implemented when CSR_COUNTERS_EN is defined.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam int unsigned MIP_MSI = 3;
  localparam int unsigned MIP_MTI = 7;
  localparam int unsigned MIP_MEI = 11;

  // Writable/readable bits of mie and mip.
  localparam logic [11:0] CSR_IRQ_MASK = 12'h888;

  localparam int unsigned IRQ_CAUSE_MSI = 3;
  localparam int unsigned IRQ_CAUSE_MTI = 7;
  localparam int unsigned IRQ_CAUSE_MEI = 11;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

endpackage

// File: rtl/csr_unit_if.sv
// Pipeline-side EX read / WB write bus of the CSR unit.
interface csr_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [11:0]     ex_csr_idx_i;
  logic            ex_csr_wr_i;
  logic [XLEN-1:0] ex_csr_rdata_o;
  logic            ex_csr_illegal_o;
  logic            wb_csr_wen_i;
  logic [1:0]      wb_csr_op_i;
  logic [11:0]     wb_csr_idx_i;
  logic [XLEN-1:0] wb_csr_src_i;
  logic            wb_retire_i;

  modport master (
    output ex_csr_idx_i, ex_csr_wr_i,
    output wb_csr_wen_i, wb_csr_op_i, wb_csr_idx_i, wb_csr_src_i, wb_retire_i,
    input  ex_csr_rdata_o, ex_csr_illegal_o
  );

  modport slave (
    input  ex_csr_idx_i, ex_csr_wr_i,
    input  wb_csr_wen_i, wb_csr_op_i, wb_csr_idx_i, wb_csr_src_i, wb_retire_i,
    output ex_csr_rdata_o, ex_csr_illegal_o
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and independent half writes.
// A write to either half suppresses the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i[31:0];
      if (wr_hi_i) cnt_d[63:32] = wdata_i[63:32];
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: EX read, WB read-modify-write, trap/MRET, interrupts.
// Define CSR_COUNTERS_EN to add 64-bit mcycle/minstret counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  csr_unit_if.slave       bus,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  input  logic            irq_sw_i,
  output logic            irq_pending_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] trap_target_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [XLEN-1:0] IRQ_MASK   = XLEN'(CSR_IRQ_MASK);
  localparam logic [XLEN-1:0] EPC_MASK   = ~XLEN'(3);
  localparam logic [XLEN-1:0] MTVEC_MASK = VECTORED_EN ? ~XLEN'(2) : ~XLEN'(3);

  logic            mst_mie_q, mst_mie_d;
  logic            mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mstatus_rd;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_cnt, minstret_cnt;
`endif

  assign mstatus_rd = XLEN'({2'b11, 3'b000, mst_mpie_q, 3'b000, mst_mie_q, 3'b000});

  // Returns {implemented, read value}; shared by the EX read and the WB old value.
  function automatic logic [XLEN:0] csr_lookup(input logic [11:0] idx);
    logic [XLEN:0] r;
    r = '0;
    case (idx)
      CSR_MSTATUS:  r = {1'b1, mstatus_rd};
      CSR_MIE:      r = {1'b1, mie_q};
      CSR_MTVEC:    r = {1'b1, mtvec_q};
      CSR_MSCRATCH: r = {1'b1, mscratch_q};
      CSR_MEPC:     r = {1'b1, mepc_q};
      CSR_MCAUSE:   r = {1'b1, mcause_q};
      CSR_MTVAL:    r = {1'b1, mtval_q};
      CSR_MIP:      r = {1'b1, mip_q};
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    r = {1'b1, XLEN'(mcycle_cnt)};
      CSR_MINSTRET:  r = {1'b1, XLEN'(minstret_cnt)};
      CSR_MCYCLEH:   if (XLEN == 32) r = {1'b1, XLEN'(mcycle_cnt[63:32])};
      CSR_MINSTRETH: if (XLEN == 32) r = {1'b1, XLEN'(minstret_cnt[63:32])};
`endif
      default:      r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN:0]   ex_lk, wb_lk;
  logic [XLEN-1:0] wb_old, wb_new;
  logic            wb_we;

  assign ex_lk = csr_lookup(bus.ex_csr_idx_i);
  assign bus.ex_csr_rdata_o   = ex_lk[XLEN-1:0];
  assign bus.ex_csr_illegal_o = !ex_lk[XLEN] ||
                                (bus.ex_csr_wr_i && (bus.ex_csr_idx_i[11:10] == 2'b11));

  assign wb_lk  = csr_lookup(bus.wb_csr_idx_i);
  assign wb_old = wb_lk[XLEN-1:0];

  always_comb begin
    wb_new = wb_old;
    case (csr_op_e'(bus.wb_csr_op_i))
      CSR_OP_RW: wb_new = bus.wb_csr_src_i;
      CSR_OP_RS: wb_new = wb_old | bus.wb_csr_src_i;
      CSR_OP_RC: wb_new = wb_old & ~bus.wb_csr_src_i;
      default:   wb_new = wb_old;
    endcase
  end

  assign wb_we = bus.wb_csr_wen_i && (bus.wb_csr_op_i != CSR_OP_NONE) && wb_lk[XLEN];

  // Later assignments win: WB write, then MRET, then trap, per register.
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;

    mip_d          = '0;
    mip_d[MIP_MSI] = irq_sw_i;
    mip_d[MIP_MTI] = irq_timer_i;
    mip_d[MIP_MEI] = irq_ext_i;

    if (wb_we) begin
      case (bus.wb_csr_idx_i)
        CSR_MSTATUS: begin
          mst_mie_d  = wb_new[MSTATUS_MIE];
          mst_mpie_d = wb_new[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wb_new & IRQ_MASK;
        CSR_MTVEC:    mtvec_d    = wb_new & MTVEC_MASK;
        CSR_MSCRATCH: mscratch_d = wb_new;
        CSR_MEPC:     mepc_d     = wb_new & EPC_MASK;
        CSR_MCAUSE:   mcause_d   = wb_new;
        CSR_MTVAL:    mtval_d    = wb_new;
        default: ;
      endcase
    end

    if (mret_i) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end

    if (trap_i) begin
      mepc_d     = trap_pc_i & EPC_MASK;
      mcause_d   = trap_cause_i;
      mtval_d    = trap_tval_i;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RESET & MTVEC_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  assign mepc_o = mepc_q;

  logic [XLEN-1:0] mtvec_base;
  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    trap_target_o = mtvec_base;
    if (mtvec_q[0] && trap_cause_i[XLEN-1])
      trap_target_o = mtvec_base + {trap_cause_i[XLEN-3:0], 2'b00};
  end

  logic [XLEN-1:0] irq_act;
  assign irq_act       = mip_q & mie_q;
  assign irq_pending_o = mst_mie_q && (|irq_act);

  always_comb begin
    irq_cause_o = '0;
    if (irq_pending_o) begin
      if (irq_act[MIP_MEI])      irq_cause_o = XLEN'(IRQ_CAUSE_MEI);
      else if (irq_act[MIP_MSI]) irq_cause_o = XLEN'(IRQ_CAUSE_MSI);
      else                       irq_cause_o = XLEN'(IRQ_CAUSE_MTI);
      irq_cause_o[XLEN-1] = 1'b1;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] cnt_wdata;
  logic        mcycle_wlo, mcycle_whi, minstret_wlo, minstret_whi;

  // XLEN=32 writes one half at a time; XLEN=64 writes both through the low address.
  assign cnt_wdata    = (XLEN == 64) ? 64'(wb_new) : {2{wb_new[31:0]}};
  assign mcycle_wlo   = wb_we && (bus.wb_csr_idx_i == CSR_MCYCLE);
  assign mcycle_whi   = wb_we && ((bus.wb_csr_idx_i == CSR_MCYCLEH) ||
                                  ((XLEN == 64) && (bus.wb_csr_idx_i == CSR_MCYCLE)));
  assign minstret_wlo = wb_we && (bus.wb_csr_idx_i == CSR_MINSTRET);
  assign minstret_whi = wb_we && ((bus.wb_csr_idx_i == CSR_MINSTRETH) ||
                                  ((XLEN == 64) && (bus.wb_csr_idx_i == CSR_MINSTRET)));

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wr_lo_i (mcycle_wlo),
    .wr_hi_i (mcycle_whi),
    .wdata_i (cnt_wdata),
    .count_o (mcycle_cnt)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (bus.wb_retire_i),
    .wr_lo_i (minstret_wlo),
    .wr_hi_i (minstret_whi),
    .wdata_i (cnt_wdata),
    .count_o (minstret_cnt)
  );
`else
  logic unused_retire;
  assign unused_retire = bus.wb_retire_i;
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (XLEN=32, MTVEC_RESET=0x100).
// Counter checks follow CSR_COUNTERS_EN.
module tb_csr_unit;
  import csr_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            trap_i = 1'b0;
  logic [XLEN-1:0] trap_cause_i = '0;
  logic [XLEN-1:0] trap_tval_i = '0;
  logic [XLEN-1:0] trap_pc_i = '0;
  logic            mret_i = 1'b0;
  logic            irq_ext_i = 1'b0;
  logic            irq_timer_i = 1'b0;
  logic            irq_sw_i = 1'b0;
  logic            irq_pending_o;
  logic [XLEN-1:0] irq_cause_o;
  logic [XLEN-1:0] trap_target_o;
  logic [XLEN-1:0] mepc_o;

  csr_unit_if #(.XLEN(XLEN)) bus ();

  csr_unit #(
    .XLEN        (XLEN),
    .MTVEC_RESET (32'h100),
    .VECTORED_EN (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .trap_i        (trap_i),
    .trap_cause_i  (trap_cause_i),
    .trap_tval_i   (trap_tval_i),
    .trap_pc_i     (trap_pc_i),
    .mret_i        (mret_i),
    .irq_ext_i     (irq_ext_i),
    .irq_timer_i   (irq_timer_i),
    .irq_sw_i      (irq_sw_i),
    .irq_pending_o (irq_pending_o),
    .irq_cause_o   (irq_cause_o),
    .trap_target_o (trap_target_o),
    .mepc_o        (mepc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] rd;
  logic            ill;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_rd(input logic [11:0] idx, input logic wr,
                        output logic [XLEN-1:0] d, output logic il);
    bus.ex_csr_idx_i = idx;
    bus.ex_csr_wr_i  = wr;
    #1;
    d  = bus.ex_csr_rdata_o;
    il = bus.ex_csr_illegal_o;
    bus.ex_csr_wr_i = 1'b0;
  endtask

  task automatic wb_set(input logic [1:0] op, input logic [11:0] idx, input logic [XLEN-1:0] src);
    bus.wb_csr_wen_i = 1'b1;
    bus.wb_csr_op_i  = op;
    bus.wb_csr_idx_i = idx;
    bus.wb_csr_src_i = src;
  endtask

  task automatic wb(input logic [1:0] op, input logic [11:0] idx, input logic [XLEN-1:0] src);
    wb_set(op, idx, src);
    tick();
    bus.wb_csr_wen_i = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    csr_rd(CSR_MTVEC, 1'b0, rd, ill);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL reset_mtvec: got %h exp %h", rd, 32'h100); end
    csr_rd(CSR_MSTATUS, 1'b0, rd, ill);
    checks++; if (rd !== 32'h1800) begin errors++; $display("FAIL reset_mstatus: got %h exp %h", rd, 32'h1800); end
    csr_rd(CSR_MIE, 1'b0, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mie: got %h exp 0", rd); end
    checks++; if (irq_pending_o !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b exp 0", irq_pending_o); end
    checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL reset_mepc: got %h exp 0", mepc_o); end
    csr_rd(12'h7C0, 1'b0, rd, ill);
    checks++; if (rd !== 32'h0 || ill !== 1'b1) begin errors++; $display("FAIL reset_unimpl: rdata %h ill %b exp 0/1", rd, ill); end
  endtask

  task automatic test_irq();
    wb(CSR_OP_RW, CSR_MIE, 32'h888);
    csr_rd(CSR_MIE, 1'b0, rd, ill);
    checks++; if (rd !== 32'h888) begin errors++; $display("FAIL irq_mie_wr: got %h exp 888", rd); end
    wb(CSR_OP_RS, CSR_MSTATUS, 32'h8);
    csr_rd(CSR_MSTATUS, 1'b0, rd, ill);
    checks++; if (rd !== 32'h1808) begin errors++; $display("FAIL irq_mstatus_rs: got %h exp 1808", rd); end
    irq_timer_i = 1'b1;
    #1;
    checks++; if (irq_pending_o !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b exp 0", irq_pending_o); end
    tick();
    csr_rd(CSR_MIP, 1'b0, rd, ill);
    checks++; if (rd !== 32'h80) begin errors++; $display("FAIL irq_mip: got %h exp 80", rd); end
    checks++; if (irq_pending_o !== 1'b1 || irq_cause_o !== 32'h80000007)
      begin errors++; $display("FAIL irq_timer: pend %b cause %h exp 1/80000007", irq_pending_o, irq_cause_o); end
    irq_ext_i = 1'b1;
    tick();
    checks++; if (irq_cause_o !== 32'h8000000B) begin errors++; $display("FAIL irq_ext_prio: got %h exp 8000000B", irq_cause_o); end
    irq_ext_i = 1'b0;
    irq_sw_i  = 1'b1;
    tick();
    checks++; if (irq_cause_o !== 32'h80000003) begin errors++; $display("FAIL irq_sw_prio: got %h exp 80000003", irq_cause_o); end
    irq_sw_i    = 1'b0;
    irq_timer_i = 1'b0;
    tick();
    checks++; if (irq_pending_o !== 1'b0 || irq_cause_o !== 32'h0)
      begin errors++; $display("FAIL irq_clear: pend %b cause %h exp 0/0", irq_pending_o, irq_cause_o); end
  endtask

  task automatic test_trap();
    wb(CSR_OP_RW, CSR_MTVEC, 32'h203);
    csr_rd(CSR_MTVEC, 1'b0, rd, ill);
    checks++; if (rd !== 32'h201) begin errors++; $display("FAIL trap_mtvec_warl: got %h exp 201", rd); end
    trap_i       = 1'b1;
    trap_pc_i    = 32'h1234;
    trap_tval_i  = 32'h0;
    trap_cause_i = 32'h2;
    #1;
    checks++; if (trap_target_o !== 32'h200) begin errors++; $display("FAIL trap_target_exc: got %h exp 200", trap_target_o); end
    trap_cause_i = 32'h80000007;
    #1;
    checks++; if (trap_target_o !== 32'h21C) begin errors++; $display("FAIL trap_target_vec: got %h exp 21C", trap_target_o); end
    tick();
    trap_i = 1'b0;
    checks++; if (mepc_o !== 32'h1234) begin errors++; $display("FAIL trap_mepc: got %h exp 1234", mepc_o); end
    csr_rd(CSR_MCAUSE, 1'b0, rd, ill);
    checks++; if (rd !== 32'h80000007) begin errors++; $display("FAIL trap_mcause: got %h exp 80000007", rd); end
    csr_rd(CSR_MSTATUS, 1'b0, rd, ill);
    checks++; if (rd !== 32'h1880) begin errors++; $display("FAIL trap_mstatus: got %h exp 1880", rd); end
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    csr_rd(CSR_MSTATUS, 1'b0, rd, ill);
    checks++; if (rd !== 32'h1888) begin errors++; $display("FAIL mret_mstatus: got %h exp 1888", rd); end
  endtask

  task automatic test_priority();
    trap_i = 1'b1; trap_pc_i = 32'h40; trap_cause_i = 32'h2; trap_tval_i = 32'hDEAD;
    wb_set(CSR_OP_RW, CSR_MEPC, 32'h80);
    tick();
    trap_i = 1'b0; bus.wb_csr_wen_i = 1'b0;
    checks++; if (mepc_o !== 32'h40) begin errors++; $display("FAIL prio_trap_mepc: got %h exp 40", mepc_o); end
    csr_rd(CSR_MTVAL, 1'b0, rd, ill);
    checks++; if (rd !== 32'hDEAD) begin errors++; $display("FAIL prio_mtval: got %h exp DEAD", rd); end
    mret_i = 1'b1;
    wb_set(CSR_OP_RC, CSR_MSTATUS, 32'h8);
    tick();
    mret_i = 1'b0; bus.wb_csr_wen_i = 1'b0;
    csr_rd(CSR_MSTATUS, 1'b0, rd, ill);
    checks++; if (rd !== 32'h1888) begin errors++; $display("FAIL prio_mret_vs_rc: got %h exp 1888", rd); end
    trap_i = 1'b1; trap_pc_i = 32'h44;
    wb_set(CSR_OP_RW, CSR_MSCRATCH, 32'h55);
    tick();
    trap_i = 1'b0; bus.wb_csr_wen_i = 1'b0;
    csr_rd(CSR_MSCRATCH, 1'b0, rd, ill);
    checks++; if (rd !== 32'h55 || mepc_o !== 32'h44)
      begin errors++; $display("FAIL prio_trap_other_reg: mscratch %h mepc %h exp 55/44", rd, mepc_o); end
    mret_i = 1'b1;
    wb_set(CSR_OP_RW, CSR_MEPC, 32'h100);
    tick();
    mret_i = 1'b0; bus.wb_csr_wen_i = 1'b0;
    csr_rd(CSR_MSTATUS, 1'b0, rd, ill);
    checks++; if (mepc_o !== 32'h100 || rd !== 32'h1888)
      begin errors++; $display("FAIL prio_mret_mepc_wr: mepc %h mstatus %h exp 100/1888", mepc_o, rd); end
  endtask

  task automatic test_warl();
    wb(CSR_OP_RW, CSR_MEPC, 32'h1003);
    checks++; if (mepc_o !== 32'h1000) begin errors++; $display("FAIL warl_mepc: got %h exp 1000", mepc_o); end
    csr_rd(CSR_MIP, 1'b1, rd, ill);
    checks++; if (ill !== 1'b0) begin errors++; $display("FAIL warl_mip_illegal: got %b exp 0", ill); end
    wb(CSR_OP_RW, CSR_MIP, 32'hFFF);
    csr_rd(CSR_MIP, 1'b0, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL warl_mip_ro: got %h exp 0", rd); end
    csr_rd(CSR_MCAUSE, 1'b1, rd, ill);
    checks++; if (ill !== 1'b0) begin errors++; $display("FAIL warl_mcause_illegal: got %b exp 0", ill); end
    csr_rd(12'hF14, 1'b1, rd, ill);
    checks++; if (ill !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL warl_f14: ill %b rdata %h exp 1/0", ill, rd); end
    wb(CSR_OP_RW, CSR_MSTATUS, 32'hFFFFFFFF);
    csr_rd(CSR_MSTATUS, 1'b0, rd, ill);
    checks++; if (rd !== 32'h1888) begin errors++; $display("FAIL warl_mstatus: got %h exp 1888", rd); end
    wb(CSR_OP_RW, CSR_MIE, 32'hFFFFFFFF);
    csr_rd(CSR_MIE, 1'b0, rd, ill);
    checks++; if (rd !== 32'h888) begin errors++; $display("FAIL warl_mie: got %h exp 888", rd); end
    wb(CSR_OP_NONE, CSR_MSCRATCH, 32'h99);
    csr_rd(CSR_MSCRATCH, 1'b0, rd, ill);
    checks++; if (rd !== 32'h55) begin errors++; $display("FAIL warl_op_none: got %h exp 55", rd); end
  endtask

  task automatic test_back_to_back();
    wb(CSR_OP_RW, CSR_MSCRATCH, 32'h0);
    wb(CSR_OP_RS, CSR_MSCRATCH, 32'h1);
    wb(CSR_OP_RS, CSR_MSCRATCH, 32'h2);
    csr_rd(CSR_MSCRATCH, 1'b0, rd, ill);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL b2b_rs: got %h exp 3", rd); end
    wb(CSR_OP_RC, CSR_MSCRATCH, 32'h1);
    csr_rd(CSR_MSCRATCH, 1'b0, rd, ill);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL b2b_rc: got %h exp 2", rd); end
  endtask

  task automatic test_counters();
`ifdef CSR_COUNTERS_EN
    wb(CSR_OP_RW, CSR_MCYCLE, 32'hFFFFFFFF);
    wb(CSR_OP_RW, CSR_MCYCLEH, 32'h0);
    csr_rd(CSR_MCYCLE, 1'b0, rd, ill);
    checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL cnt_lo_hold: got %h exp FFFFFFFF", rd); end
    tick();
    csr_rd(CSR_MCYCLEH, 1'b0, rd, ill);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL cnt_carry: got %h exp 1", rd); end
    csr_rd(CSR_MINSTRET, 1'b0, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cnt_instret_idle: got %h exp 0", rd); end
    for (int unsigned i = 0; i < 5; i++) begin
      bus.wb_retire_i = 1'b1;
      tick();
      bus.wb_retire_i = 1'b0;
      tick();
    end
    csr_rd(CSR_MINSTRET, 1'b0, rd, ill);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL cnt_instret: got %h exp 5", rd); end
`else
    csr_rd(CSR_MCYCLE, 1'b0, rd, ill);
    checks++; if (rd !== 32'h0 || ill !== 1'b1) begin errors++; $display("FAIL cnt_absent_mcycle: rdata %h ill %b exp 0/1", rd, ill); end
    csr_rd(CSR_MINSTRETH, 1'b0, rd, ill);
    checks++; if (rd !== 32'h0 || ill !== 1'b1) begin errors++; $display("FAIL cnt_absent_minstreth: rdata %h ill %b exp 0/1", rd, ill); end
`endif
  endtask

  task automatic test_async_reset();
    wb(CSR_OP_RW, CSR_MSCRATCH, 32'hAB);
    wb_set(CSR_OP_RW, CSR_MSCRATCH, 32'h77);
    #2;
    rst = 1'b1;
    #1;
    csr_rd(CSR_MSCRATCH, 1'b0, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL async_rst_mscratch: got %h exp 0", rd); end
    csr_rd(CSR_MTVEC, 1'b0, rd, ill);
    checks++; if (rd !== 32'h100 || mepc_o !== 32'h0)
      begin errors++; $display("FAIL async_rst_mtvec_mepc: mtvec %h mepc %h exp 100/0", rd, mepc_o); end
    tick();
    bus.wb_csr_wen_i = 1'b0;
    rst = 1'b0;
    tick();
    csr_rd(CSR_MSCRATCH, 1'b0, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL async_rst_drop_wb: got %h exp 0", rd); end
  endtask

  initial begin
    bus.ex_csr_idx_i = '0;
    bus.ex_csr_wr_i  = 1'b0;
    bus.wb_csr_wen_i = 1'b0;
    bus.wb_csr_op_i  = '0;
    bus.wb_csr_idx_i = '0;
    bus.wb_csr_src_i = '0;
    bus.wb_retire_i  = 1'b0;
    test_reset();
    test_irq();
    test_trap();
    test_priority();
    test_warl();
    test_back_to_back();
    test_counters();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
